// File: rtl/regfile_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);
  localparam int REG_ZERO      = 0;

  typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
  typedef logic [XLEN_DEFAULT-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register outstanding-write counters: issue stall, read-side busy
// flags and a sticky protocol error flag.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEFAULT,
  parameter  int CNT_W = 2,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  output logic              issue_ready,
  input  logic              flush,
  output logic              sb_err
);

  localparam logic [AW-1:0]    ZERO    = AW'(REG_ZERO);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt [NREGS];
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;

  // Stall decision looks only at the counter, never at this cycle's writeback.
  assign issue_ready = (issue_rd == ZERO) || (cnt[issue_rd] != CNT_MAX);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = issue_valid && issue_ready && (issue_rd != ZERO) &&
               (issue_rd == AW'(r)) && !flush;
      dec[r] = we && (wa == AW'(r)) && (cnt[r] != '0) && !flush;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc[r] && !dec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec[r] && !inc[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  // Unscheduled writebacks still land in the data array; the counter just stays at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_err <= 1'b0;
    else if (!flush && ((issue_valid && !issue_ready) ||
                        (we && (wa != ZERO) && (cnt[wa] == '0))))
      sb_err <= 1'b1;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] a;
    logic          hit;
    assign a          = rd_addr[i*AW +: AW];
    assign hit        = we && (wa == a) && (cnt[a] != '0);
    assign rd_busy[i] = (a != ZERO) && ((cnt[a] - CNT_W'(hit)) != '0);
  end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with optional writeback bypass, registered debug
// port and integrated RAW-hazard scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEFAULT,
  parameter  int NREGS  = NREGS_DEFAULT,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  parameter  int CNT_W  = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                flush,
  output logic                sb_err,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (we && (wa != ZERO)) begin
      regs[wa] <= wd;
    end
  end

  // Sampled before the array updates, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dbg_data <= '0;
    else
      dbg_data <= (dbg_addr == ZERO) ? '0 : regs[dbg_addr];
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];
    assign rd_data[i*XLEN +: XLEN] =
      (a == ZERO)                         ? '0 :
      ((BYPASS != 0) && we && (wa == a))  ? wd :
                                            regs[a];
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .CNT_W (CNT_W),
    .NRD   (NRD)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .we          (we),
    .wa          (wa),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .flush       (flush),
    .sb_err      (sb_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: bypassing and non-bypassing instances
// share stimulus; a negedge monitor drains the expectation queue.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int NRD = 2;
  localparam int AW = 5;

  logic                clk = 1'b0;
  logic                rst;
  reg_addr_t           a0, a1;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data_nb;
  logic [NRD-1:0]      rd_busy, rd_busy_nb;
  logic                we, issue_valid, flush;
  reg_addr_t           wa, issue_rd, dbg_addr;
  xword_t              wd, dbg_data, dbg_data_nb;
  logic                issue_ready, issue_ready_nb, sb_err, sb_err_nb;

  assign rd_addr = {a1, a0};

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .flush(flush), .sb_err(sb_err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0), .CNT_W(2)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .we(we), .wa(wa), .wd(wd), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready_nb), .flush(flush), .sb_err(sb_err_nb),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  typedef enum int {S_RD0, S_RD1, S_RDNB, S_BUSY0, S_BUSY1, S_READY, S_ERR, S_DBG} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] actual(sel_t s);
    case (s)
      S_RD0:   return rd_data[31:0];
      S_RD1:   return rd_data[63:32];
      S_RDNB:  return rd_data_nb[31:0];
      S_BUSY0: return {31'b0, rd_busy[0]};
      S_BUSY1: return {31'b0, rd_busy[1]};
      S_READY: return {31'b0, issue_ready};
      S_ERR:   return {31'b0, sb_err};
      S_DBG:   return dbg_data;
      default: return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [31:0] got;
    got = actual(e.sel);
    tests++;
    if (got !== e.exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", e.name, got, e.exp, $time);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) checkOutput(q.pop_front());
  end

  task automatic expectOut(input sel_t s, input logic [31:0] v, input string n);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic applyStimulus(input logic iwe, input reg_addr_t iwa, input xword_t iwd,
                               input logic iv, input reg_addr_t ird, input logic ifl,
                               input reg_addr_t ia0, input reg_addr_t ia1, input reg_addr_t idbg);
    we = iwe; wa = iwa; wd = iwd;
    issue_valid = iv; issue_rd = ird; flush = ifl;
    a0 = ia0; a1 = ia1; dbg_addr = idbg;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2, 1);
    expectOut(S_RD0, 0, "rst_rd0");
    expectOut(S_READY, 1, "rst_ready");
    expectOut(S_ERR, 0, "rst_err");
    expectOut(S_DBG, 0, "rst_dbg");
    step();
    step();
    rst = 1'b0;

    for (int i = 1; i < 32; i++) begin
      applyStimulus(0, 0, 0, 0, 5'(i), 0, 5'(i), 5'(32 - i), 5'(i));
      expectOut(S_RD0, 0, "init_rd0");
      expectOut(S_RD1, 0, "init_rd1");
      expectOut(S_BUSY0, 0, "init_busy0");
      expectOut(S_BUSY1, 0, "init_busy1");
      expectOut(S_READY, 1, "init_ready");
      expectOut(S_DBG, 0, "init_dbg");
      step();
    end

    // Scheduled write to x5: bypass vs. non-bypass, and debug latency.
    applyStimulus(0, 0, 0, 1, 5, 0, 5, 0, 0);
    expectOut(S_READY, 1, "x5_issue_ready");
    expectOut(S_BUSY0, 0, "x5_issue_busy");
    step();
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 5);
    expectOut(S_RD0, 32'hDEADBEEF, "x5_bypass");
    expectOut(S_RDNB, 0, "x5_nobypass_old");
    expectOut(S_BUSY0, 0, "x5_wb_busy");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 5);
    expectOut(S_RD0, 32'hDEADBEEF, "x5_after");
    expectOut(S_RDNB, 32'hDEADBEEF, "x5_nobypass_new");
    expectOut(S_DBG, 0, "x5_dbg_prewrite");
    step();
    expectOut(S_DBG, 32'hDEADBEEF, "x5_dbg");
    expectOut(S_ERR, 0, "x5_err");
    step();

    // x0 is immune to writes and issue.
    applyStimulus(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
    expectOut(S_RD0, 0, "x0_rd0");
    expectOut(S_RD1, 0, "x0_rd1");
    expectOut(S_RDNB, 0, "x0_rdnb");
    expectOut(S_READY, 1, "x0_ready");
    expectOut(S_BUSY0, 0, "x0_busy");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectOut(S_RD0, 0, "x0_after");
    expectOut(S_DBG, 0, "x0_dbg");
    expectOut(S_ERR, 0, "x0_err");
    step();

    // Saturate x7 then drain with three writebacks.
    applyStimulus(0, 0, 0, 1, 7, 0, 7, 0, 0);
    expectOut(S_READY, 1, "x7_i1_ready");
    expectOut(S_BUSY0, 0, "x7_i1_busy");
    step();
    expectOut(S_READY, 1, "x7_i2_ready");
    expectOut(S_BUSY0, 1, "x7_i2_busy");
    step();
    expectOut(S_READY, 1, "x7_i3_ready");
    expectOut(S_BUSY0, 1, "x7_i3_busy");
    step();
    applyStimulus(0, 0, 0, 0, 7, 0, 7, 0, 0);
    expectOut(S_READY, 0, "x7_sat_ready");
    expectOut(S_BUSY0, 1, "x7_sat_busy");
    expectOut(S_ERR, 0, "x7_sat_err");
    step();
    applyStimulus(1, 7, 32'h70, 0, 7, 0, 7, 0, 0);
    expectOut(S_BUSY0, 1, "x7_wb1_busy");
    expectOut(S_READY, 0, "x7_wb1_ready");
    expectOut(S_RD0, 32'h70, "x7_wb1_rd");
    expectOut(S_RDNB, 0, "x7_wb1_rdnb");
    step();
    applyStimulus(1, 7, 32'h71, 0, 7, 0, 7, 0, 0);
    expectOut(S_READY, 1, "x7_wb2_ready");
    expectOut(S_BUSY0, 1, "x7_wb2_busy");
    expectOut(S_RDNB, 32'h70, "x7_wb2_rdnb");
    step();
    applyStimulus(1, 7, 32'h72, 0, 7, 0, 7, 0, 0);
    expectOut(S_BUSY0, 0, "x7_wb3_busy");
    expectOut(S_READY, 1, "x7_wb3_ready");
    expectOut(S_RDNB, 32'h71, "x7_wb3_rdnb");
    step();
    applyStimulus(0, 0, 0, 0, 7, 0, 7, 0, 0);
    expectOut(S_BUSY0, 0, "x7_done_busy");
    expectOut(S_RD0, 32'h72, "x7_done_rd");
    expectOut(S_ERR, 0, "x7_done_err");
    step();

    // Simultaneous issue and writeback on x3 keeps the count at 1.
    applyStimulus(0, 0, 0, 1, 3, 0, 3, 0, 0);
    expectOut(S_READY, 1, "x3_i_ready");
    expectOut(S_BUSY0, 0, "x3_i_busy");
    step();
    applyStimulus(1, 3, 32'h33, 1, 3, 0, 3, 0, 0);
    expectOut(S_READY, 1, "x3_both_ready");
    expectOut(S_BUSY0, 0, "x3_both_busy");
    expectOut(S_RD0, 32'h33, "x3_both_rd");
    step();
    applyStimulus(0, 0, 0, 0, 3, 0, 3, 0, 0);
    expectOut(S_BUSY0, 1, "x3_after_busy");
    expectOut(S_RD0, 32'h33, "x3_after_rd");
    expectOut(S_ERR, 0, "x3_after_err");
    step();

    // Flush clears every counter but still performs the write.
    applyStimulus(0, 0, 0, 1, 4, 0, 4, 3, 0);
    expectOut(S_READY, 1, "x4_i1_ready");
    step();
    expectOut(S_BUSY0, 1, "x4_i2_busy");
    expectOut(S_READY, 1, "x4_i2_ready");
    step();
    applyStimulus(1, 4, 32'h12, 1, 4, 1, 4, 3, 0);
    expectOut(S_BUSY0, 1, "x4_fl_busy");
    expectOut(S_BUSY1, 1, "x3_fl_busy");
    expectOut(S_RD0, 32'h12, "x4_fl_rd");
    step();
    applyStimulus(0, 0, 0, 0, 4, 0, 4, 3, 0);
    expectOut(S_RD0, 32'h12, "x4_post_rd");
    expectOut(S_RDNB, 32'h12, "x4_post_rdnb");
    expectOut(S_BUSY0, 0, "x4_post_busy");
    expectOut(S_BUSY1, 0, "x3_post_busy");
    expectOut(S_READY, 1, "x4_post_ready");
    expectOut(S_ERR, 0, "x4_post_err");
    step();

    // Unscheduled writeback to x9 sets the sticky error.
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 9, 0, 0);
    expectOut(S_RD0, 32'h99, "x9_wb_rd");
    expectOut(S_RDNB, 0, "x9_wb_rdnb");
    expectOut(S_BUSY0, 0, "x9_wb_busy");
    expectOut(S_ERR, 0, "x9_wb_err");
    step();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0, 9);
    expectOut(S_RD0, 32'h99, "x9_after_rd");
    expectOut(S_RDNB, 32'h99, "x9_after_rdnb");
    expectOut(S_ERR, 1, "x9_err_set");
    step();

    // Asynchronous reset in the middle of outstanding work.
    applyStimulus(0, 0, 0, 1, 6, 0, 9, 0, 9);
    expectOut(S_ERR, 1, "err_sticky");
    expectOut(S_DBG, 32'h99, "x9_dbg");
    step();
    applyStimulus(0, 0, 0, 0, 6, 0, 9, 6, 9);
    expectOut(S_BUSY1, 1, "x6_busy_prerst");
    expectOut(S_RD0, 32'h99, "x9_prerst");
    step();
    rst = 1'b1;
    expectOut(S_RD0, 0, "arst_rd0");
    expectOut(S_RDNB, 0, "arst_rdnb");
    expectOut(S_BUSY1, 0, "arst_busy1");
    expectOut(S_READY, 1, "arst_ready");
    expectOut(S_DBG, 0, "arst_dbg");
    expectOut(S_ERR, 0, "arst_err");
    step();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 6, 9);
    expectOut(S_RD0, 0, "post_rst_rd0");
    expectOut(S_BUSY1, 0, "post_rst_busy1");
    expectOut(S_ERR, 0, "post_rst_err");
    step();

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
